// File: rtl/adder_result_collector.sv
// adder_result_collector
// Collects WINDOW consecutive Sum/Overflow samples from the 4-bit adder,
// accumulates the signed sums into a saturating total, counts overflow
// events, and presents each completed window on a registered valid/ready
// port. One finished window can wait in the output registers and a second
// can wait in the accumulators before the adder is stalled through Busy.
module adder_result_collector #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 12,
    parameter int WINDOW = 8,
    parameter int CNT_W  = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              En,
    input  logic [DATA_W-1:0] Sum,
    input  logic              Overflow,
    output logic              Busy,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [ACC_W-1:0]  Total,
    output logic [CNT_W-1:0]  Ov_Count,
    output logic              Sat
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    logic [0:0]        state_reg,     state_next;
    logic [ACC_W-1:0]  acc_reg,       acc_next;
    logic [CNT_W-1:0]  cnt_reg,       cnt_next;
    logic [CNT_W-1:0]  ovc_reg,       ovc_next;
    logic              sat_reg,       sat_next;
    logic              out_valid_reg, out_valid_next;
    logic [ACC_W-1:0]  total_reg,     total_next;
    logic [CNT_W-1:0]  ov_count_reg,  ov_count_next;
    logic              out_sat_reg,   out_sat_next;

    // Single-step accumulate values for the sample currently on the inputs
    logic [ACC_W:0]    sum_wide;
    logic [ACC_W:0]    acc_wide;
    logic              clip_hi;
    logic              clip_lo;
    logic [ACC_W-1:0]  acc_step;
    logic [CNT_W-1:0]  ovc_step;
    logic              sat_step;
    logic              accept;
    logic              buf_free;

    // The add is one bit wider than the accumulator, so a disagreement of the
    // top two bits means the true sum left the representable range.
    assign sum_wide = {{(ACC_W+1-DATA_W){Sum[DATA_W-1]}}, Sum};
    assign acc_wide = {acc_reg[ACC_W-1], acc_reg} + sum_wide;
    assign clip_hi  = ~acc_wide[ACC_W] &  acc_wide[ACC_W-1];
    assign clip_lo  =  acc_wide[ACC_W] & ~acc_wide[ACC_W-1];

    // Saturating accumulate, sticky clip flag and saturating overflow count
    always_comb begin
        acc_step = acc_wide[ACC_W-1:0];
        if (clip_hi) begin
            acc_step = ACC_MAX;
        end else if (clip_lo) begin
            acc_step = ACC_MIN;
        end
        sat_step = sat_reg | clip_hi | clip_lo;
        ovc_step = ovc_reg;
        if (Overflow && (ovc_reg != {CNT_W{1'b1}})) begin
            ovc_step = ovc_reg + 1'b1;
        end
    end

    assign accept   = En && (state_reg == ST_ACCUM);
    assign buf_free = !out_valid_reg || Out_Ready;

    // Next-state logic for the window accumulators, the FSM and the output port
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        ovc_next       = ovc_reg;
        sat_next       = sat_reg;
        total_next     = total_reg;
        ov_count_next  = ov_count_reg;
        out_sat_next   = out_sat_reg;
        // A consumed result drops valid unless something reloads it below
        out_valid_next = Out_Ready ? 1'b0 : out_valid_reg;

        case (state_reg)
            ST_ACCUM: begin
                if (accept) begin
                    if (cnt_reg == CNT_LAST) begin
                        if (buf_free) begin
                            total_next     = acc_step;
                            ov_count_next  = ovc_step;
                            out_sat_next   = sat_step;
                            out_valid_next = 1'b1;
                            acc_next       = '0;
                            ovc_next       = '0;
                            sat_next       = 1'b0;
                            cnt_next       = '0;
                        end else begin
                            // Park the finished window in the accumulators
                            acc_next   = acc_step;
                            ovc_next   = ovc_step;
                            sat_next   = sat_step;
                            cnt_next   = '0;
                            state_next = ST_HOLD;
                        end
                    end else begin
                        acc_next = acc_step;
                        ovc_next = ovc_step;
                        sat_next = sat_step;
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (Out_Ready) begin
                    total_next     = acc_reg;
                    ov_count_next  = ovc_reg;
                    out_sat_next   = sat_reg;
                    out_valid_next = 1'b1;
                    acc_next       = '0;
                    ovc_next       = '0;
                    sat_next       = 1'b0;
                    cnt_next       = '0;
                    state_next     = ST_ACCUM;
                end
            end
            default: begin
                state_next = ST_ACCUM;
            end
        endcase
    end

    // State and output registers; reset discards any partial or pending window
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg     <= ST_ACCUM;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovc_reg       <= '0;
            sat_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            total_reg     <= '0;
            ov_count_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            ovc_reg       <= ovc_next;
            sat_reg       <= sat_next;
            out_valid_reg <= out_valid_next;
            total_reg     <= total_next;
            ov_count_reg  <= ov_count_next;
            out_sat_reg   <= out_sat_next;
        end
    end

    assign Busy      = (state_reg == ST_HOLD);
    assign Out_Valid = out_valid_reg;
    assign Total     = total_reg;
    assign Ov_Count  = ov_count_reg;
    assign Sat       = out_sat_reg;

endmodule

// File: tb/tb_adder_result_collector.sv
// Testbench for adder_result_collector: directed stimulus pushes hand-computed
// window results into queues; independent monitors pop and compare on each
// valid/ready handshake. Instance a uses defaults, instance b uses ACC_W=5.
module tb_adder_result_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        en_a, ov_a, ready_a, busy_a, valid_a, sat_a;
    logic [3:0]  sum_a, ov_count_a;
    logic [11:0] total_a;

    logic        en_b, ov_b, ready_b, busy_b, valid_b, sat_b;
    logic [3:0]  sum_b, ov_count_b;
    logic [4:0]  total_b;

    int checks = 0;
    int errors = 0;

    // Expected results packed as {sat, ov_count[3:0], total[11:0]}
    logic [16:0] qa[$];
    logic [16:0] qb[$];

    adder_result_collector dut_a (
        .Clk(clk), .Rst_n(rst_n), .En(en_a), .Sum(sum_a), .Overflow(ov_a),
        .Busy(busy_a), .Out_Valid(valid_a), .Out_Ready(ready_a),
        .Total(total_a), .Ov_Count(ov_count_a), .Sat(sat_a)
    );

    adder_result_collector #(.ACC_W(5)) dut_b (
        .Clk(clk), .Rst_n(rst_n), .En(en_b), .Sum(sum_b), .Overflow(ov_b),
        .Busy(busy_b), .Out_Valid(valid_b), .Out_Ready(ready_b),
        .Total(total_b), .Ov_Count(ov_count_b), .Sat(sat_b)
    );

    function automatic logic [16:0] exp_r(input logic [11:0] t, input logic [3:0] o, input logic s);
        return {s, o, t};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor for instance a: compare on every handshake
    always @(negedge clk) begin : mon_a
        logic [16:0] e;
        if (rst_n && valid_a && ready_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_result actual=%0h required=none", total_a);
            end else begin
                e = qa.pop_front();
                $display("a result total=%0h ov_count=%0d sat=%0b", total_a, ov_count_a, sat_a);
                chk("a_total", 32'(total_a), 32'(e[11:0]));
                chk("a_ov_count", 32'(ov_count_a), 32'(e[15:12]));
                chk("a_sat", 32'(sat_a), 32'(e[16]));
            end
        end
    end

    // Monitor for instance b (5-bit accumulator)
    always @(negedge clk) begin : mon_b
        logic [16:0] e;
        if (rst_n && valid_b && ready_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_result actual=%0h required=none", total_b);
            end else begin
                e = qb.pop_front();
                $display("b result total=%0h ov_count=%0d sat=%0b", total_b, ov_count_b, sat_b);
                chk("b_total", 32'(total_b), 32'(e[4:0]));
                chk("b_ov_count", 32'(ov_count_b), 32'(e[15:12]));
                chk("b_sat", 32'(sat_b), 32'(e[16]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [3:0] s, input logic o);
        en_a = 1'b1; sum_a = s; ov_a = o;
        step();
        en_a = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] s, input logic o);
        en_b = 1'b1; sum_b = s; ov_b = o;
        step();
        en_b = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_valid"}, 32'(valid_a), 32'd0);
        chk({tag, "_total"}, 32'(total_a), 32'd0);
        chk({tag, "_ov_count"}, 32'(ov_count_a), 32'd0);
        chk({tag, "_sat"}, 32'(sat_a), 32'd0);
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    endtask

    initial begin
        logic [7:0] ovp;
        rst_n = 1'b0;
        en_a = 1'b0; sum_a = '0; ov_a = 1'b0; ready_a = 1'b0;
        en_b = 1'b0; sum_b = '0; ov_b = 1'b0; ready_b = 1'b1;
        #12;
        check_reset_a("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Eight samples of +1, consumer always ready: one-cycle pulse, total 8
        ready_a = 1'b1;
        qa.push_back(exp_r(12'h008, 4'd0, 1'b0));
        for (int i = 0; i < 8; i++) begin
            send_a(4'h1, 1'b0);
            if (i < 7) chk("lat_early_valid", 32'(valid_a), 32'd0);
        end
        chk("lat_valid", 32'(valid_a), 32'd1);
        step();
        chk("pulse_valid_low", 32'(valid_a), 32'd0);

        // Eight samples of -8, five overflow flags: total -64, count 5
        ovp = 8'b0110_1011;
        qa.push_back(exp_r(12'hFC0, 4'd5, 1'b0));
        for (int i = 0; i < 8; i++) send_a(4'h8, ovp[i]);
        step();

        // Stalled consumer: 16 samples of +2 fill output and pending buffers
        ready_a = 1'b0;
        qa.push_back(exp_r(12'h010, 4'd0, 1'b0));
        qa.push_back(exp_r(12'h010, 4'd0, 1'b0));
        qa.push_back(exp_r(12'h00A, 4'd1, 1'b0));
        for (int i = 0; i < 16; i++) begin
            send_a(4'h2, 1'b0);
            if (i == 7) begin
                chk("stall_valid_after_8", 32'(valid_a), 32'd1);
                chk("stall_busy_after_8", 32'(busy_a), 32'd0);
            end
            if (i == 14) chk("stall_busy_after_15", 32'(busy_a), 32'd0);
        end
        chk("hold_busy", 32'(busy_a), 32'd1);
        // 17th sample held while busy: ignored, outputs stable
        en_a = 1'b1; sum_a = 4'h3; ov_a = 1'b1;
        step();
        chk("hold_busy_2", 32'(busy_a), 32'd1);
        chk("hold_total_stable", 32'(total_a), 32'h010);
        step();
        chk("hold_busy_3", 32'(busy_a), 32'd1);
        ready_a = 1'b1;
        step();
        chk("hold_exit_busy", 32'(busy_a), 32'd0);
        chk("hold_exit_valid", 32'(valid_a), 32'd1);
        step();
        chk("hold_drain_valid", 32'(valid_a), 32'd0);
        en_a = 1'b0;
        for (int i = 0; i < 7; i++) send_a(4'h1, 1'b0);
        chk("resume_valid", 32'(valid_a), 32'd1);

        // Window end coincides with a consume: back-to-back results, no stall
        ready_a = 1'b0;
        qa.push_back(exp_r(12'hFF8, 4'd0, 1'b0));
        for (int i = 0; i < 8; i++) begin
            if (i == 7) ready_a = 1'b1;
            send_a(4'hF, 1'b0);
            chk("b2b_busy", 32'(busy_a), 32'd0);
            if (i < 7) chk("b2b_total_stable", 32'(total_a), 32'h00A);
        end
        chk("b2b_valid", 32'(valid_a), 32'd1);
        chk("b2b_total_new", 32'(total_a), 32'hFF8);
        step();
        chk("b2b_valid_low", 32'(valid_a), 32'd0);

        // Asynchronous reset mid-window discards the partial window
        for (int i = 0; i < 5; i++) send_a(4'h1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_a("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        qa.push_back(exp_r(12'h028, 4'd0, 1'b0));
        for (int i = 0; i < 8; i++) send_a(4'h5, 1'b0);
        step();

        // Asynchronous reset during HOLD
        ready_a = 1'b0;
        for (int i = 0; i < 16; i++) send_a(4'h1, 1'b0);
        chk("rst_hold_busy_before", 32'(busy_a), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_a("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        ready_a = 1'b1;
        qa.push_back(exp_r(12'h030, 4'd0, 1'b0));
        for (int i = 0; i < 8; i++) send_a(4'h6, 1'b0);
        step();

        // Narrow accumulator: +7 x8 clips at +15, then a clean zero window
        qb.push_back(exp_r(12'h00F, 4'd0, 1'b1));
        for (int i = 0; i < 8; i++) send_b(4'h7, 1'b0);
        qb.push_back(exp_r(12'h000, 4'd0, 1'b0));
        for (int i = 0; i < 8; i++) send_b(4'h0, 1'b0);
        step();
        step();

        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_result_collector.md
# adder_result_collector

Downstream stage for the 4-bit registered adder. It accepts each enabled `Sum`/`Overflow` pair and accumulates `WINDOW` consecutive sums as signed values into a saturating wide total. It also counts overflow events. Each completed window is presented on a registered valid/ready output port with one window of buffering. A slow consumer stalls the adder only after two windows are pending.

## Interface
- `DATA_W`, default 4: width of incoming `Sum`, read as two's complement.
- `ACC_W`, default 12: width of the signed accumulator and the `Total` output.
- `WINDOW`, default 8: number of accepted samples per result; legal range 2..2^CNT_W-1.
- `CNT_W`, default 4: width of the sample counter and of `Ov_Count`.
- `Clk`  in  1  rising-edge clock, shared with the adder.
- `Rst_n`  in  1  asynchronous active-low reset.
- `En`  in  1  sample valid; the same enable that drives the adder.
- `Sum`  in  DATA_W  adder result.
- `Overflow`  in  1  adder overflow flag for this `Sum`.
- `Busy`  out  1  collector cannot accept; upstream must hold `En` and data.
- `Out_Valid`  out  1  `Total`, `Ov_Count` and `Sat` hold a completed window.
- `Out_Ready`  in  1  consumer takes the result this cycle.
- `Total`  out  ACC_W  signed sum of the window's `Sum` values, saturated.
- `Ov_Count`  out  CNT_W  number of samples in the window with `Overflow`=1; saturates at all-ones.
- `Sat`  out  1  the accumulator clipped at least once during the window.

## Operation
- A sample is accepted when `En`=1 and `Busy`=0. When `Busy`=1 the sample is ignored and nothing changes.
- Accumulate step: `acc_next = clip(acc + sign_extend(Sum))`.
  - The add is performed at ACC_W+1 bits.
  - Results are clipped to the range -2^(ACC_W-1) .. 2^(ACC_W-1)-1.
  - Any clip sets the window's sticky `sat` flag.
- On each accepted sample, `ovc` increments if `Overflow`=1, holding at all-ones. `cnt` increments.
- Window end is the accepted sample with `cnt`=WINDOW-1. The output buffer is free when `Out_Valid`=0 or `Out_Ready`=1.
  - Buffer free: the final `acc_next`, `ovc` and `sat` load into the output registers and `Out_Valid`=1. `acc`, `ovc`, `sat` and `cnt` clear. State stays ACCUM.
  - Buffer not free: the final values are kept in `acc`/`ovc`/`sat` as a pending result, and state goes to HOLD.
- States:
  - ACCUM: accepting samples. `Busy`=0.
  - HOLD: a pending result is waiting. `Busy`=1 and no samples are accepted. On `Out_Ready`=1 the pending result loads into the output registers (`Out_Valid` stays 1), the accumulators clear, and the state returns to ACCUM.
- `Out_Valid` falls after `Out_Ready`=1 only when no new result loads in the same cycle.
- While `Out_Valid`=1 and `Out_Ready`=0, the output registers are stable.
- `Busy` is decoded combinationally from the state register (state==HOLD) only, never from inputs.

## Timing
- Reset (async assert, any cycle, including mid-window or during HOLD):
  - State goes to ACCUM.
  - `acc`, `cnt`, `ovc`, `sat` are cleared.
  - `Out_Valid`=0, `Total`=0, `Ov_Count`=0, `Sat`=0, `Busy`=0.
  - A partial window is discarded.
- Latency: `Out_Valid` rises on the clock edge that accepts the WINDOW-th sample, i.e. it is visible one cycle after that sample is presented.
- Throughput: one sample per cycle. With `Out_Ready` tied high there are no stalls, and `Out_Valid` pulses for one cycle per window.
- Window completion and `Out_Ready`=1 in the same cycle: the old result is consumed and the new one loads. `Out_Valid` stays 1 and no HOLD occurs.
- Entering HOLD:
  - `Busy` rises the cycle after the window-end sample.
  - Samples presented on that cycle and later are ignored until the cycle after `Out_Ready`=1 is seen in HOLD.
  - Exit from HOLD is the edge where `Out_Ready`=1; `Busy`=0 from the next cycle.
- `Ov_Count` saturation applies only when WINDOW exceeds the CNT_W range; with the defaults it never saturates.

## Test plan
- Reset, then 8 samples with `Sum`=4'h1, `Overflow`=0 and `Out_Ready`=1 → one cycle with `Out_Valid`=1, `Total`=12'h008, `Ov_Count`=0, `Sat`=0.
- 8 samples with `Sum`=4'h8 (-8), of which 5 have `Overflow`=1 → `Total`=12'hFC0 (-64), `Ov_Count`=5.
- Override `ACC_W`=5 and send 8 samples with `Sum`=4'h7 → `Total`=5'h0F (+15), `Sat`=1. The next window of 8 samples with `Sum`=4'h0 → `Total`=0, `Sat`=0.
- `Out_Ready`=0 and 16 consecutive samples with `Sum`=4'h2 → `Out_Valid` after sample 8 and `Busy`=1 after sample 16. A 17th sample is ignored. Raise `Out_Ready` → the first result has `Total`=16 and the second is presented next with `Total`=16. `Busy` falls the cycle after, and the 17th sample is then re-accepted as the first sample of the next window.
- Window end coinciding with `Out_Ready`=1 while `Out_Valid`=1 → the new result replaces the old with no gap, and `Busy` stays 0 throughout.
- Assert `Rst_n`=0 asynchronously after 5 samples, and separately during HOLD → all outputs go to 0 immediately. After release, the window restarts and 8 fresh samples produce a correct result.
